clkdiv_prog: RTL and testbench
==============================

Name: clkdiv_prog

Overview:
- Parametrised, run-time programmable clock divider for the timer/control path; successor to the fixed divide-by-100 divider.
- Generates a 50 % duty square wave `clk_out` and a one-cycle `tick` strobe in the `clk` domain, for use as a clock-enable.
- Half-period is reprogrammable on the fly with a load/ack handshake. New values take effect only at a half-period boundary, so `clk_out` never glitches.

Parameters:
- CNT_W, 26: width of the counter, the half-period register and `half_in`.
- HALF_DEF, 50: reset half-period in `clk` cycles. Must satisfy 1 <= HALF_DEF <= 2^CNT_W-1. Output period = 2*half.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; when low, counter and `clk_out` hold.
- half_in  in  CNT_W  requested half-period in cycles.
- load  in  1  one-cycle request to adopt `half_in`.
- clk_out  out  1  divided square wave, registered.
- tick  out  1  one-cycle pulse on each rising toggle of `clk_out`, registered.
- load_ack  out  1  one-cycle pulse in the cycle the new half-period takes effect.
- load_err  out  1  one-cycle pulse in the cycle after a load with `half_in`==0.

Behaviour:
- Reset (async, rst_n=0): count=0, half_reg=HALF_DEF, clk_out=0, tick=0, pend_valid=0, pend_val=0, load_ack=0, load_err=0.
- Counting, on each edge with en=1:
  - if count==half_reg-1: count<=0, clk_out<=~clk_out ("wrap"); else count<=count+1.
  - tick<=1 only on a wrap where clk_out goes 0->1; otherwise tick<=0.
  - Consequence: clk_out first rises after HALF_DEF enabled edges; tick is high in exactly the same cycle clk_out first reads 1.
- en=0: count and clk_out hold; tick<=0.
- Load capture (edge with load=1):
  - half_in==0: load ignored, load_err<=1 next cycle, pending state unchanged.
  - half_in!=0: pend_val<=half_in, pend_valid<=1.
  - A newer load overwrites pend_val; only one ack is issued.
- Apply:
  - With en=1, at a wrap whose edge sees pend_valid==1 already set before that cycle: half_reg<=pend_val, pend_valid<=0, load_ack<=1.
  - The new half-period governs the next half-period. A load arriving in the wrap cycle itself applies at the following wrap.
- Apply while disabled: if en=0 and pend_valid==1 at an edge: half_reg<=pend_val, count<=0, pend_valid<=0, load_ack<=1. clk_out holds its level.
- Simultaneous apply and load (pend_valid==1, apply edge, load=1 with valid half_in):
  - the old pend_val is applied and acked;
  - the new value is captured and pend_valid stays 1;
  - a second ack follows at a later apply point.
- half_reg==1: clk_out toggles every enabled cycle (period 2). tick pulses every 2nd cycle.
- Counter never exceeds half_reg-1; no wrap through 2^CNT_W.
- Reset mid-operation: immediate return to reset values; pending load is discarded with no ack.
- load_ack and load_err are never high for more than one cycle per event.

Optional Feature:
- Macro CLKDIV_SYNC_CLR_EN.
- Defined: adds input port clr (1 bit). An edge with clr=1 forces count<=0, clk_out<=0, tick<=0, regardless of en.
  - clr has priority over counting and over disabled-apply.
  - pend_valid, pend_val and half_reg are unaffected; a pending value is still applied at a later wrap.
- Not defined: no clr port and no associated logic.

Test Plan:
- Reset release, en=1 constant, default HALF_DEF=50 -> clk_out rises after edge 50, falls after edge 100; period 100 cycles; tick high 1 cycle every 100 cycles, coincident with clk_out rising.
- Load half_in=3 mid-half-period -> pend held until next wrap; load_ack one pulse at that wrap; subsequent clk_out period 6 cycles, tick every 6.
- load with half_in=0 -> load_err one pulse the next cycle; period stays 100; no load_ack.
- Two loads (7 then 5) within one half-period -> single load_ack; period becomes 10.
- en low for 37 cycles mid-count -> clk_out/count frozen, no tick; resume completes the remaining count exactly. Also: load 4 while en=0 -> ack next cycle, count=0, then period 8 after en=1.
- rst_n pulsed low with pending load and clk_out=1 -> immediate clk_out=0, tick=0; no ack; period back to 100. With CLKDIV_SYNC_CLR_EN: clr pulse forces clk_out=0, count restart, pending still applied.

Source files
------------

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: run-time programmable clock divider, 50% duty square wave plus rising-edge tick strobe.
// Latency: outputs registered; a load is applied at the first wrap after capture (next edge if en=0).
// Backpressure: none; a newer load before the apply point replaces the pending value (one ack only).
// Ports: clk, rst_n (async, active low), en (count enable), half_in/load (half-period request),
//        clk_out (divided wave), tick (pulse on clk_out rising), load_ack (new half-period live),
//        load_err (zero half-period rejected). Define CLKDIV_SYNC_CLR_EN to add clr (sync restart).
module clkdiv_prog #(
    parameter int          CNT_W    = 26,
    parameter int unsigned HALF_DEF = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] half_in,
    input  logic             load,
`ifdef CLKDIV_SYNC_CLR_EN
    input  logic             clr,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic             load_err
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(HALF_DEF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             load_ack_q, load_ack_d;
    logic             load_err_q, load_err_d;
    logic             clr_act;
    logic             wrap;
    logic             apply;

`ifdef CLKDIV_SYNC_CLR_EN
    assign clr_act = clr;
`else
    assign clr_act = 1'b0;
`endif

    always_comb begin
        count_d    = count_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        load_ack_d = 1'b0;
        load_err_d = load && (half_in == '0);
        wrap       = 1'b0;
        apply      = 1'b0;

        if (clr_act) begin
            // Restart the waveform low; pending/half state is left alone so
            // a queued value still lands at a later wrap.
            count_d   = '0;
            clk_out_d = 1'b0;
        end else if (en) begin
            wrap = (count_q == half_q - ONE);
            if (wrap) begin
                count_d   = '0;
                clk_out_d = ~clk_out_q;
                tick_d    = ~clk_out_q;
                // Only a value captured before this edge may change the
                // period, so the switch always happens on a half boundary.
                apply     = pend_vld_q;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            // Frozen output: there is no boundary to wait for, adopt at once
            // and restart the half-period from zero.
            apply = pend_vld_q;
            if (pend_vld_q) begin
                count_d = '0;
            end
        end

        if (apply) begin
            half_d     = pend_val_q;
            pend_vld_d = 1'b0;
            load_ack_d = 1'b1;
        end

        // Capture after apply so a load in the apply cycle stays pending.
        if (load && (half_in != '0)) begin
            pend_val_d = half_in;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            half_q     <= HALF_RST;
            pend_val_q <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            load_ack_q <= load_ack_d;
            load_err_q <= load_err_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign load_ack = load_ack_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: directed scenarios plus randomized traffic for clkdiv_prog.
// Reference model tracks "edges remaining until the next toggle" rather than a counter.
module tb_clkdiv_prog;

    localparam int CNT_W    = 26;
    localparam int HALF_DEF = 50;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             load;
    logic [CNT_W-1:0] half_in;
`ifdef CLKDIV_SYNC_CLR_EN
    logic             clr;
`endif
    logic             clk_out;
    logic             tick;
    logic             load_ack;
    logic             load_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int m_half;
    int m_rem;
    int m_pval;
    bit m_pv;
    bit m_out;
    bit m_tick;
    bit m_ack;
    bit m_err;

    always #5 clk = ~clk;

    clkdiv_prog #(.CNT_W(CNT_W), .HALF_DEF(HALF_DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .half_in  (half_in),
        .load     (load),
`ifdef CLKDIV_SYNC_CLR_EN
        .clr      (clr),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .load_ack (load_ack),
        .load_err (load_err)
    );

    function automatic logic [3:0] dut_v();
        return {clk_out, tick, load_ack, load_err};
    endfunction

    function automatic logic [3:0] mdl_v();
        return {m_out, m_tick, m_ack, m_err};
    endfunction

    task automatic model_reset();
        m_half = HALF_DEF;
        m_rem  = HALF_DEF;
        m_pval = 0;
        m_pv   = 1'b0;
        m_out  = 1'b0;
        m_tick = 1'b0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
    endtask

    // One rising edge of the divider, described as "edges left in this half".
    task automatic model_edge(input bit e, input bit ld, input logic [CNT_W-1:0] hin, input bit cl);
        bit pv_was = m_pv;
        m_err  = ld && (hin == 0);
        m_tick = 1'b0;
        m_ack  = 1'b0;
        if (cl) begin
            m_out = 1'b0;
            m_rem = m_half;
        end else if (e) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_out  = !m_out;
                m_tick = m_out;
                if (pv_was) begin
                    m_half = m_pval;
                    m_pv   = 1'b0;
                    m_ack  = 1'b1;
                end
                m_rem = m_half;
            end
        end else if (pv_was) begin
            m_half = m_pval;
            m_rem  = m_half;
            m_pv   = 1'b0;
            m_ack  = 1'b1;
        end
        if (ld && (hin != 0)) begin
            m_pv   = 1'b1;
            m_pval = int'(hin);
        end
    endtask

    task automatic step(input bit e, input bit ld, input logic [CNT_W-1:0] hin, input bit cl);
        en      = e;
        load    = ld;
        half_in = hin;
`ifdef CLKDIV_SYNC_CLR_EN
        clr     = cl;
`endif
        @(posedge clk);
        model_edge(e, ld, hin, cl);
        cyc++;
        #1;
        load = 1'b0;
`ifdef CLKDIV_SYNC_CLR_EN
        clr  = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        half_in = '0;
`ifdef CLKDIV_SYNC_CLR_EN
        clr     = 1'b0;
`endif
        #3;
        n_checks++;
        if (dut_v() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: out,tick,ack,err=%b required 0000", dut_v());
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut_v() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_held: out,tick,ack,err=%b required 0000", dut_v());
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_default_period();
        int first_rise = -1;
        int first_fall = -1;
        int ticks = 0;
        bit prev = clk_out;
        for (int i = 1; i <= 250; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL default_period edge %0d: out,tick,ack,err=%b required %b", i, dut_v(), mdl_v());
            end
            if (clk_out && !prev && first_rise < 0) first_rise = i;
            if (!clk_out && prev && first_fall < 0) first_fall = i;
            if (tick) ticks++;
            prev = clk_out;
        end
        n_checks++;
        if (first_rise != 50) begin
            n_fail++;
            $display("FAIL default_first_rise: edge %0d required 50", first_rise);
        end
        n_checks++;
        if (first_fall != 100) begin
            n_fail++;
            $display("FAIL default_first_fall: edge %0d required 100", first_fall);
        end
        n_checks++;
        if (ticks != 3) begin
            n_fail++;
            $display("FAIL default_tick_count: %0d ticks in 250 edges required 3", ticks);
        end
    endtask

    task automatic test_load_err();
        int n;
        int acks = 0;
        for (int i = 0; i < 400 && !tick; i++) step(1'b1, 1'b0, '0, 1'b0);
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL load_err_align: tick=%b required 1", tick);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, '0, 1'b0);
        n_checks++;
        if (load_err !== 1'b1 || dut_v() !== mdl_v()) begin
            n_fail++;
            $display("FAIL load_err_pulse: out,tick,ack,err=%b required %b", dut_v(), mdl_v());
        end
        for (n = 12; n <= 200; n++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL load_err_run edge %0d: out,tick,ack,err=%b required %b", n, dut_v(), mdl_v());
            end
            if (load_ack) acks++;
            if (tick) break;
        end
        n_checks++;
        if (n != 100 || acks != 0) begin
            n_fail++;
            $display("FAIL load_err_period: tick at edge %0d with %0d acks required 100 with 0", n, acks);
        end
    endtask

    task automatic test_enable_hold();
        int n;
        for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 37; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            n_checks++;
            if (clk_out !== 1'b1 || tick !== 1'b0 || dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL enable_hold edge %0d: out,tick,ack,err=%b required 1000", i, dut_v());
            end
        end
        for (n = 1; n <= 200; n++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL enable_resume edge %0d: out,tick,ack,err=%b required %b", n, dut_v(), mdl_v());
            end
            if (tick) break;
        end
        n_checks++;
        if (n != 80) begin
            n_fail++;
            $display("FAIL enable_resume_len: tick after %0d resumed edges required 80", n);
        end
    endtask

    task automatic test_load();
        int n;
        int t1 = -1;
        int t2 = -1;
        for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, CNT_W'(3), 1'b0);
        for (n = 1; n <= 200; n++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL load3_wait edge %0d: out,tick,ack,err=%b required %b", n, dut_v(), mdl_v());
            end
            if (load_ack) break;
        end
        n_checks++;
        if (n != 29 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL load3_ack: ack after %0d edges clk_out=%b required 29 and 0", n, clk_out);
        end
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL load3_run edge %0d: out,tick,ack,err=%b required %b", i, dut_v(), mdl_v());
            end
            if (tick && t1 < 0) t1 = i;
            else if (tick && t2 < 0) t2 = i;
        end
        n_checks++;
        if (t1 != 3 || t2 != 9) begin
            n_fail++;
            $display("FAIL load3_period: ticks at %0d,%0d required 3,9", t1, t2);
        end
    endtask

    task automatic test_double_load();
        int acks = 0;
        int t1 = -1;
        int t2 = -1;
        for (int i = 0; i < 40 && !tick; i++) step(1'b1, 1'b0, '0, 1'b0);
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL double_align: tick=%b required 1", tick);
        end
        step(1'b1, 1'b1, CNT_W'(7), 1'b0);
        step(1'b1, 1'b1, CNT_W'(5), 1'b0);
        for (int i = 3; i <= 42; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL double_run edge %0d: out,tick,ack,err=%b required %b", i, dut_v(), mdl_v());
            end
            if (load_ack) acks++;
            if (tick && t1 < 0) t1 = i;
            else if (tick && t2 < 0) t2 = i;
        end
        n_checks++;
        if (acks != 1 || t1 != 8 || t2 != 18) begin
            n_fail++;
            $display("FAIL double_load: acks=%0d ticks %0d,%0d required 1 acks ticks 8,18", acks, t1, t2);
        end
    endtask

    task automatic test_disabled_load();
        int t1 = -1;
        int t2 = -1;
        for (int i = 0; i < 40 && !tick; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, CNT_W'(4), 1'b0);
        n_checks++;
        if (load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_load_capture: load_ack=%b required 0", load_ack);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (load_ack !== 1'b1 || clk_out !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_load_ack: load_ack=%b clk_out=%b required 1,1", load_ack, clk_out);
        end
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL dis_load_run edge %0d: out,tick,ack,err=%b required %b", i, dut_v(), mdl_v());
            end
            if (tick && t1 < 0) t1 = i;
            else if (tick && t2 < 0) t2 = i;
        end
        n_checks++;
        if (t1 != 8 || t2 != 16) begin
            n_fail++;
            $display("FAIL dis_load_period: ticks %0d,%0d required 8,16", t1, t2);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int t1 = -1;
        int t2 = -1;
        for (int i = 0; i < 40 && !tick; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, CNT_W'(9), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_v() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: out,tick,ack,err=%b required 0000", dut_v());
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 160; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL reset_mid_run edge %0d: out,tick,ack,err=%b required %b", i, dut_v(), mdl_v());
            end
            if (load_ack) acks++;
            if (tick && t1 < 0) t1 = i;
            else if (tick && t2 < 0) t2 = i;
        end
        n_checks++;
        if (acks != 0 || t1 != 50 || t2 != 150) begin
            n_fail++;
            $display("FAIL reset_mid_period: acks=%0d ticks %0d,%0d required 0 acks ticks 50,150", acks, t1, t2);
        end
    endtask

`ifdef CLKDIV_SYNC_CLR_EN
    task automatic test_clr();
        int n;
        int t2 = -1;
        step(1'b1, 1'b1, CNT_W'(6), 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        n_checks++;
        if (dut_v() !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_force: out,tick,ack,err=%b required 0000", dut_v());
        end
        for (n = 1; n <= 200; n++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL clr_run edge %0d: out,tick,ack,err=%b required %b", n, dut_v(), mdl_v());
            end
            if (load_ack) break;
        end
        n_checks++;
        if (n != 50 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_apply: ack after %0d edges tick=%b required 50 and 1", n, tick);
        end
        for (int i = 1; i <= 15; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (tick && t2 < 0) t2 = i;
        end
        n_checks++;
        if (t2 != 12) begin
            n_fail++;
            $display("FAIL clr_period: next tick after %0d edges required 12", t2);
        end
    endtask
`endif

    task automatic test_random();
        bit e;
        bit ld;
        bit cl;
        logic [CNT_W-1:0] hin;
        for (int i = 0; i < 3000; i++) begin
            e   = ($urandom_range(0, 7) != 0);
            ld  = (i == 0) || ($urandom_range(0, 19) == 0);
            hin = (i == 0) ? CNT_W'(1) : CNT_W'($urandom_range(0, 9));
`ifdef CLKDIV_SYNC_CLR_EN
            cl  = ($urandom_range(0, 99) == 0);
`else
            cl  = 1'b0;
`endif
            step(e, ld, hin, cl);
            n_checks++;
            if (dut_v() !== mdl_v()) begin
                n_fail++;
                $display("FAIL random cycle %0d: out,tick,ack,err=%b required %b", i, dut_v(), mdl_v());
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_period();
        test_load_err();
        test_enable_hold();
        test_load();
        test_double_load();
        test_disabled_load();
        test_reset_mid();
`ifdef CLKDIV_SYNC_CLR_EN
        test_clr();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
